// File: rtl/ff_bank_multimode_if.sv
// Bus bundle for ff_bank_multimode: control/data inputs and registered outputs.
interface ff_bank_multimode_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             clr_err;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic [WIDTH-1:0] conflict;
  logic [CNT_W-1:0] conflict_cnt;
  logic             err;

  modport master (
    output en, mode, a, b, clr_err,
    input  q, qbar, conflict, conflict_cnt, err
  );

  modport slave (
    input  en, mode, a, b, clr_err,
    output q, qbar, conflict, conflict_cnt, err
  );
endinterface

// File: rtl/ff_bank_multimode.sv
// Bank of WIDTH flip-flops with shared SR/JK/D/T mode select, a fixed policy
// for the SR S=R=1 case, and conflict reporting (per-bit flag, saturating
// event counter, sticky error).
module ff_bank_multimode #(
  parameter int               WIDTH          = 4,
  parameter int               INVALID_POLICY = 0,
  parameter int               CNT_W          = 8,
  parameter logic [WIDTH-1:0] RESET_VAL      = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  ff_bank_multimode_if.slave  bus
);

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] conflict_q, conflict_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Next-state: per-bit flip-flop behaviour plus conflict bookkeeping.
  // The clear is applied before a same-edge conflict is counted.
  always_comb begin
    q_d        = q_q;
    conflict_d = '0;
    cnt_d      = cnt_q;
    err_d      = err_q;

    if (bus.clr_err) begin
      cnt_d = '0;
      err_d = 1'b0;
    end

    if (bus.en) begin
      for (int i = 0; i < WIDTH; i++) begin
        unique case (bus.mode)
          MODE_SR: begin
            unique case ({bus.a[i], bus.b[i]})
              2'b00: q_d[i] = q_q[i];
              2'b10: q_d[i] = 1'b1;
              2'b01: q_d[i] = 1'b0;
              default: begin
                case (INVALID_POLICY)
                  1:       q_d[i] = 1'b1;
                  2:       q_d[i] = 1'b0;
                  3:       q_d[i] = ~q_q[i];
                  default: q_d[i] = q_q[i];
                endcase
              end
            endcase
          end
          MODE_JK: begin
            unique case ({bus.a[i], bus.b[i]})
              2'b00:   q_d[i] = q_q[i];
              2'b10:   q_d[i] = 1'b1;
              2'b01:   q_d[i] = 1'b0;
              default: q_d[i] = ~q_q[i];
            endcase
          end
          MODE_D:  q_d[i] = bus.a[i];
          MODE_T:  q_d[i] = q_q[i] ^ bus.a[i];
          default: q_d[i] = q_q[i];
        endcase
      end

      if (bus.mode == MODE_SR) begin
        conflict_d = bus.a & bus.b;
      end

      // One count per conflicting edge regardless of how many bits collide.
      if (|conflict_d) begin
        err_d = 1'b1;
        if (cnt_d != CNT_MAX) begin
          cnt_d = cnt_d + CNT_W'(1);
        end
      end
    end
  end

  // State registers with synchronous reset that overrides everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q        <= RESET_VAL;
      conflict_q <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      q_q        <= q_d;
      conflict_q <= conflict_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  assign bus.q            = q_q;
  assign bus.qbar         = ~q_q;
  assign bus.conflict     = conflict_q;
  assign bus.conflict_cnt = cnt_q;
  assign bus.err          = err_q;

endmodule

// File: doc/ff_bank_multimode.md
# ff_bank_multimode

Parametrised, clocked bank of WIDTH independent flip-flops. It extends the single-bit SR flip-flop to a selectable SR / JK / D / T mode and gives the SR "both inputs high" case a defined, parameter-selected policy. Each illegal SR request is detected and reported through a per-bit flag, a saturating event counter and a sticky error bit. It is used as a general state-holding primitive wherever a bank of flags needs set/reset/toggle control.

## Interface
- WIDTH, 4, number of flip-flop channels (≥1)
- INVALID_POLICY, 0, SR-mode action when S=R=1: 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle
- CNT_W, 8, conflict counter width (≥2)
- RESET_VAL, {WIDTH{1'b0}}, Q value loaded on reset
- clk  input  1  rising-edge clock, sole clock
- rst  input  1  synchronous, active-high reset
- en  input  1  update enable; 0 = hold all state
- mode  input  2  00 SR, 01 JK, 10 D, 11 T; applies to all channels
- a  input  WIDTH  per-bit S / J / D / T
- b  input  WIDTH  per-bit R / K; ignored in D and T modes
- clr_err  input  1  clears conflict_cnt and err
- q  output  WIDTH  registered state
- qbar  output  WIDTH  always ~q; never equal to q
- conflict  output  WIDTH  per-bit: SR-mode S=R=1 was sampled at the last enabled edge
- conflict_cnt  output  CNT_W  saturating count of enabled SR-mode edges with any conflicting bit
- err  output  1  sticky: at least one conflict since reset or clr_err

## Operation
- Per bit i, at an edge with en=1, next q[i]:
  - SR: a=0,b=0 hold; a=1,b=0 →1; a=0,b=1 →0; a=1,b=1 per INVALID_POLICY
  - JK: 00 hold, 10 →1, 01 →0, 11 toggle
  - D: q[i]=a[i]
  - T: a[i]=1 toggles, a[i]=0 holds
- Mode is sampled on the same edge as the data. Mode changes take effect immediately; there is no mode-transition state.
- conflict[i]=1 after an enabled edge only if mode=SR and a[i]=b[i]=1; otherwise 0. JK 11 is legal and never flags.
- conflict_cnt increments by 1 per enabled SR edge with |(a&b) (not once per bit). It saturates at 2^CNT_W−1 and does not wrap.
- err is set on the same edge as any counted conflict and stays set until clr_err or rst.
- clr_err and a new conflict on the same edge: the clear applies first, then the count, giving conflict_cnt=1, err=1.
- clr_err does not affect q or conflict.
- en=0: q, conflict_cnt and err hold; conflict is driven to 0; clr_err is still honoured.

## Timing
- All outputs are registered and change only at the rising edge of clk. Input-to-q latency is 1 cycle.
- rst=1 at an edge: q=RESET_VAL, qbar=~RESET_VAL, conflict=0, conflict_cnt=0, err=0. rst overrides en, clr_err and all data.
- Reset mid-operation: state is lost at that edge. The first enabled edge after rst deasserts evaluates normally from RESET_VAL.
- Before the first reset edge, outputs are undefined. The bench must assert rst for ≥1 edge.
- qbar is derived from the q register, so q and qbar never both read 1 or both read 0.

## Test plan
- Reset: WIDTH=4, RESET_VAL=4'b1010, rst for 2 edges → q=1010, qbar=0101, conflict=0, conflict_cnt=0, err=0.
- SR sequence, policy 0: a/b = 0/1, 0/0, 0/1, 1/0, 1/1 on all bits → q = 0000, 0000, 0000, 1111, 1111. After the last edge: conflict=1111, conflict_cnt=1, err=1. Rerun with policy 3 → final q=0000.
- Policies 1 and 2, q=0101, a=b=1111 → q=1111 under policy 1, q=0000 under policy 2. conflict_cnt increments by exactly 1 per edge, not by 4.
- JK/T/D: JK a=b=1111 from q=0011 → 1100 with conflict=0. T a=0110 → 1010. D a=1001 → 1001. conflict_cnt unchanged throughout.
- Saturation and clear: CNT_W=2, five SR conflict edges → conflict_cnt=3 (held, no wrap). clr_err with no conflict → cnt=0, err=0. clr_err together with a conflict → cnt=1, err=1.
- Enable: en=0 with T a=1111 and SR a=b=1111 → q unchanged, conflict=0, cnt unchanged. en=0 with clr_err → cnt=0, err=0. rst asserted mid-sequence with en=1 → RESET_VAL on that edge.
